// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and defaults.
package cpu_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode-facing port.
interface instr_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [31:0]       out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is visible combinationally on pop_data.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_fire;
    logic             push_fire;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_fire  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_fire = push && (!full || pop_fire);
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
            if (push_fire && !pop_fire)      count <= count + CW'(1);
            else if (pop_fire && !push_fire) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_fire) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited sequential PC issue, in-order response buffering, redirect flush.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    instr_fetch_if.master     bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = ADDR_W + 32;

    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     pcq_count;
    logic              buf_full;
    logic              buf_empty;
    logic              pcq_full;
    logic              pcq_empty;
    logic [EW-1:0]     buf_head;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW:0]       credits_used;
    logic              req_fire;
    logic              rsp_fire;
    logic              keep_rsp;
    logic              out_fire;
    logic              show;
    logic [1:0]        unused_redirect_lo;

    assign unused_redirect_lo = redirect_pc[1:0];

    // buffered plus in-flight never exceeds the buffer, so every response has a slot
    assign credits_used       = {1'b0, buf_count} + {1'b0, outstanding};
    assign bus.imem_req_valid = rst_n && !halt && !redirect_valid &&
                                (credits_used < (CW+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = rst_n && bus.imem_rsp_valid;
    assign keep_rsp = rsp_fire && (discard == '0);
    assign show     = rst_n && !buf_empty;
    assign out_fire = show && bus.out_ready;

    assign bus.out_valid = show;
    assign bus.out_pc    = show ? buf_head[EW-1:32] : '0;
    assign bus.out_instr = show ? buf_head[31:0]    : '0;

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .pop_data  (rsp_pc),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep_rsp),
        .push_data ({rsp_pc, bus.imem_rsp_data}),
        .pop       (out_fire),
        .flush     (redirect_valid),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (redirect_valid)  fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (req_fire)   fetch_pc <= fetch_pc + ADDR_W'(4);

            if (req_fire && !rsp_fire)      outstanding <= outstanding + CW'(1);
            else if (rsp_fire && !req_fire) outstanding <= outstanding - CW'(1);

            // after a redirect everything still in flight is stale
            if (redirect_valid)             discard <= outstanding - CW'(rsp_fire);
            else if (rsp_fire && !keep_rsp) discard <= discard - CW'(1);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) rsp_fire |-> !pcq_empty);
    assert property (@(posedge clk) disable iff (!rst_n) req_fire |-> !pcq_full);
    assert property (@(posedge clk) disable iff (!rst_n) pcq_count == outstanding);
    assert property (@(posedge clk) disable iff (!rst_n)
                     (keep_rsp && !redirect_valid) |-> (!buf_full || out_fire));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model plus a queue-based fetch-stream reference.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } redir_vec_t;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    instr_fetch_if #(.ADDR_W(32)) bus ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .bus            (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_due = 0;
    int epoch    = 0;
    int seg_start = 0;

    int          lat = 1;
    bit          rand_lat = 0;
    int          rdy_prob = 100;
    int          ordy_prob = 100;
    bit          halt_v = 0;
    bit          redir_v = 0;
    logic [31:0] redir_pc_v = '0;
    bit          rst_v = 1;

    logic        c_req_valid, c_out_valid;
    logic [31:0] c_req_addr, c_out_pc, c_out_instr;
    logic [31:0] exp_addr = RST_PC;

    mreq_t        mq[$];
    fetch_entry_t fq[$];
    logic [31:0]  cons_q[$];

    function automatic logic [31:0] memfn(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] get_cons(int i);
        if (i < cons_q.size()) return {32'h0, cons_q[i]};
        return 64'hDEAD_0000_DEAD_0000;
    endfunction

    task automatic step();
        bit           rsp_now;
        bit           exp_req;
        mreq_t        r;
        fetch_entry_t e;
        int           l;
        @(negedge clk);
        cyc++;
        rsp_now = !rst_v && (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? memfn(mq[0].addr) : 32'h0;
        bus.imem_req_ready = ($urandom_range(99) < rdy_prob);
        bus.out_ready      = ($urandom_range(99) < ordy_prob);
        halt           = halt_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc_v;
        rst_n          = !rst_v;
        #1;
        c_req_valid = bus.imem_req_valid;
        c_req_addr  = bus.imem_req_addr;
        c_out_valid = bus.out_valid;
        c_out_pc    = bus.out_pc;
        c_out_instr = bus.out_instr;

        if (rst_v) begin
            check("rst_req_valid", {63'h0, c_req_valid}, 64'h0);
            check("rst_out_valid", {63'h0, c_out_valid}, 64'h0);
            check("rst_out_pc", {32'h0, c_out_pc}, 64'h0);
            check("rst_out_instr", {32'h0, c_out_instr}, 64'h0);
        end else begin
            exp_req = !halt_v && !redir_v && ((fq.size() + mq.size()) < DEPTH);
            check("req_valid", {63'h0, c_req_valid}, {63'h0, exp_req});
            if (c_req_valid) check("req_addr", {32'h0, c_req_addr}, {32'h0, exp_addr});
            check("out_valid", {63'h0, c_out_valid}, {63'h0, fq.size() > 0});
            if (fq.size() > 0) begin
                check("out_pc", {32'h0, c_out_pc}, {32'h0, fq[0].pc});
                check("out_instr", {32'h0, c_out_instr}, {32'h0, fq[0].instr});
            end else begin
                check("idle_out_pc", {32'h0, c_out_pc}, 64'h0);
                check("idle_out_instr", {32'h0, c_out_instr}, 64'h0);
            end
        end

        if (rst_v) begin
            mq.delete();
            fq.delete();
            cons_q.delete();
            exp_addr  = RST_PC;
            epoch++;
            last_due  = cyc;
            seg_start = 0;
        end else begin
            if (rsp_now) begin
                r = mq.pop_front();
                if (r.epoch == epoch) begin
                    e.pc    = r.exp_pc;
                    e.instr = memfn(r.exp_pc);
                    fq.push_back(e);
                end
            end
            if (fq.size() > 0 && bus.out_ready && !redir_v && !rsp_now) begin
                e = fq.pop_front();
                cons_q.push_back(e.pc);
            end else if (fq.size() > 0 && bus.out_ready && !redir_v && rsp_now) begin
                // head existed before this cycle's push only if more than the pushed entry is queued
                if (fq.size() > 1 || r.epoch != epoch) begin
                    e = fq.pop_front();
                    cons_q.push_back(e.pc);
                end
            end
            if (c_req_valid && bus.imem_req_ready) begin
                l = rand_lat ? int'($urandom_range(4, 1)) : lat;
                r.addr   = c_req_addr;
                r.exp_pc = exp_addr;
                r.epoch  = epoch;
                r.due    = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
                last_due = r.due;
                mq.push_back(r);
                exp_addr = exp_addr + 32'd4;
            end
            if (redir_v) begin
                fq.delete();
                epoch++;
                exp_addr  = {redir_pc_v[31:2], 2'b00};
                seg_start = cons_q.size();
            end
        end
    endtask

    task automatic do_reset(int n);
        rst_v = 1;
        repeat (n) step();
        rst_v = 0;
    endtask

    task automatic redirect_step(logic [31:0] pc);
        redir_v    = 1;
        redir_pc_v = pc;
        step();
        redir_v    = 0;
    endtask

    task automatic check_contig(string name);
        for (int i = seg_start; i + 1 < cons_q.size(); i++)
            check(name, {32'h0, cons_q[i+1]}, {32'h0, cons_q[i] + 32'd4});
    endtask

    redir_vec_t vecs[4];
    int n0;

    initial begin
        vecs[0] = '{rpc: 32'h0000_0203, exp0: 32'h0000_0200, exp1: 32'h0000_0204};
        vecs[1] = '{rpc: 32'h0000_0100, exp0: 32'h0000_0100, exp1: 32'h0000_0104};
        vecs[2] = '{rpc: 32'hFFFF_FFFC, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
        vecs[3] = '{rpc: 32'h0000_1001, exp0: 32'h0000_1000, exp1: 32'h0000_1004};

        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0; bus.out_ready = 1'b0;

        do_reset(3);

        // streaming at memory latency 1
        lat = 1; rdy_prob = 100; ordy_prob = 100;
        repeat (20) step();
        check("stream_count", {32'h0, 32'(cons_q.size())}, 64'd18);
        for (int i = 0; i < 6; i++)
            check("stream_pc", get_cons(i), {32'h0, 32'(i * 4)});

        // decode stall: buffer fills, requests stop, nothing lost on resume
        ordy_prob = 0;
        repeat (10) step();
        check("stall_no_req", {63'h0, c_req_valid}, 64'h0);
        check("stall_valid", {63'h0, c_out_valid}, 64'h1);
        rdy_prob = 0; ordy_prob = 100;
        n0 = cons_q.size();
        repeat (6) step();
        check("stall_buffered", {32'h0, 32'(cons_q.size() - n0)}, 64'd4);
        rdy_prob = 100;
        repeat (4) step();
        check_contig("stall_contig");

        // latency 3, two requests in flight, then redirect
        do_reset(2);
        lat = 3;
        repeat (2) step();
        redirect_step(32'h0000_0100);
        repeat (8) step();
        check("lat3_first_pc", get_cons(0), 64'h100);

        // redirect table, each redirect lands on an out handshake
        lat = 1;
        for (int v = 0; v < 4; v++) begin
            repeat (3) step();
            redirect_step(vecs[v].rpc);
            check("redir_hs_cycle", {63'h0, c_out_valid && bus.out_ready}, 64'h1);
            repeat (6) step();
            check("redir_pc0", get_cons(seg_start), {32'h0, vecs[v].exp0});
            check("redir_pc1", get_cons(seg_start + 1), {32'h0, vecs[v].exp1});
        end

        // halt mid-stream
        lat = 2;
        redirect_step(32'h0000_0400);
        repeat (6) step();
        halt_v = 1;
        n0 = cons_q.size();
        repeat (6) step();
        check("halt_no_req", {63'h0, c_req_valid}, 64'h0);
        check("halt_drain", {63'h0, (cons_q.size() - n0) > 0}, 64'h1);
        halt_v = 0;
        repeat (8) step();
        check_contig("halt_contig");

        // reset in the middle of a stream
        lat = 1;
        repeat (4) step();
        check("pre_reset_valid", {63'h0, c_out_valid}, 64'h1);
        do_reset(1);
        check("mid_reset_valid", {63'h0, c_out_valid}, 64'h0);
        repeat (6) step();
        check("restart_pc0", get_cons(0), {32'h0, RST_PC});
        check("restart_pc1", get_cons(1), {32'h0, RST_PC + 32'd4});

        // randomized traffic against the reference
        rand_lat = 1; rdy_prob = 70; ordy_prob = 60;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 5) halt_v = !halt_v;
            if ($urandom_range(99) < 3) redirect_step($urandom);
            else step();
        end
        halt_v = 0; ordy_prob = 100; rdy_prob = 100;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
